// File: rtl/ocp_arb_pkg.sv
// Shared encodings for the two-requester OCP arbiter: FSM states, OCP MCmd and SResp codes.
package ocp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    localparam logic [2:0] MCMD_IDLE = 3'b000;
    localparam logic [2:0] MCMD_WR   = 3'b001;
    localparam logic [2:0] MCMD_RD   = 3'b010;

    localparam logic [1:0] SRESP_NULL = 2'b00;
    localparam logic [1:0] SRESP_DVA  = 2'b01;
    localparam logic [1:0] SRESP_FAIL = 2'b10;
    localparam logic [1:0] SRESP_ERR  = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; the pointer moves to the loser when a transaction completes.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_idx,
    output logic       pick
);

    logic ptr;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        pick = 1'b0;
        if (req == 2'b11) begin
            pick = ptr;
        end else if (req[1]) begin
            pick = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (done) begin
            ptr <= ~done_idx;
        end
    end

endmodule

// File: rtl/ocp_req_arbiter.sv
// Arbitrates two request ports onto one OCP master, one transaction at a time.
// Define OCP_ARB_TIMEOUT_EN to add a response watchdog that errors out after TIMEOUT RESP cycles.
module ocp_req_arbiter
    import ocp_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [1:0][AW-1:0]  req_addr,
    input  logic [1:0][3:0]     req_id,
    input  logic [1:0][DW-1:0]  req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DW-1:0]       rsp_data,
    output logic [3:0]          rsp_id,
    output logic                rsp_err,
    output logic [2:0]          MCmd,
    output logic [AW-1:0]       MAddr,
    output logic [2:0]          MTagID,
    output logic [DW-1:0]       MData,
    output logic                MDataValid,
    output logic                MRespAccept,
    input  logic                SCmdAccept,
    input  logic                SDataAccept,
    input  logic [1:0]          SResp,
    input  logic [DW-1:0]       SData
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("ocp_req_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_t state;
    logic       grant;
    logic       cur_write;
    logic [3:0] cur_id;
    logic       data_seen;
    logic       pick;
    logic       resp_timeout;
    logic       resp_fire;

`ifdef OCP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;

    // Counter sits at zero outside RESP, so it is cleared on every RESP entry.
    always_ff @(posedge clk) begin
        if (rst || state != ST_RESP) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign resp_timeout = (tmo_cnt == CW'(TIMEOUT - 1));
`else
    assign resp_timeout = 1'b0;
`endif

    assign resp_fire = (state == ST_RESP) && ((SResp != SRESP_NULL) || resp_timeout);

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .req      (req_valid),
        .done     (resp_fire),
        .done_idx (grant),
        .pick     (pick)
    );

    always_ff @(posedge clk) begin
        req_ready <= '0;
        rsp_valid <= '0;
        rsp_data  <= '0;
        rsp_id    <= '0;
        rsp_err   <= 1'b0;
        if (rst) begin
            state       <= ST_IDLE;
            grant       <= 1'b0;
            cur_write   <= 1'b0;
            cur_id      <= '0;
            data_seen   <= 1'b0;
            MCmd        <= MCMD_IDLE;
            MAddr       <= '0;
            MTagID      <= '0;
            MData       <= '0;
            MDataValid  <= 1'b0;
            MRespAccept <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant      <= pick;
                        cur_write  <= req_write[pick];
                        cur_id     <= req_id[pick];
                        data_seen  <= 1'b0;
                        MCmd       <= req_write[pick] ? MCMD_WR : MCMD_RD;
                        MAddr      <= req_addr[pick];
                        MTagID     <= {2'b00, pick};
                        MDataValid <= req_write[pick];
                        MData      <= req_write[pick] ? req_wdata[pick] : '0;
                        state      <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    // Early data acceptance is remembered so the write can skip DATA.
                    if (cur_write && SDataAccept) begin
                        data_seen <= 1'b1;
                    end
                    if (SCmdAccept) begin
                        req_ready[grant] <= 1'b1;
                        MCmd             <= MCMD_IDLE;
                        MAddr            <= '0;
                        MTagID           <= '0;
                        if (!cur_write || SDataAccept || data_seen) begin
                            MDataValid  <= 1'b0;
                            MData       <= '0;
                            MRespAccept <= 1'b1;
                            state       <= ST_RESP;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (SDataAccept) begin
                        MDataValid  <= 1'b0;
                        MData       <= '0;
                        MRespAccept <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_fire) begin
                        rsp_valid[grant] <= 1'b1;
                        rsp_id           <= cur_id;
                        if (SResp != SRESP_NULL) begin
                            rsp_data <= cur_write ? '0 : SData;
                            rsp_err  <= (SResp == SRESP_FAIL) || (SResp == SRESP_ERR);
                        end else begin
                            rsp_err <= 1'b1;
                        end
                        MRespAccept <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ocp_req_arbiter.sv
// Directed self-checking bench for ocp_req_arbiter; timeout case only with OCP_ARB_TIMEOUT_EN.
module tb_ocp_req_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_write = '0;
    logic [1:0][31:0] req_addr  = '0;
    logic [1:0][3:0]  req_id    = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_data;
    logic [3:0]       rsp_id;
    logic             rsp_err;
    logic [2:0]       MCmd;
    logic [31:0]      MAddr;
    logic [2:0]       MTagID;
    logic [31:0]      MData;
    logic             MDataValid;
    logic             MRespAccept;
    logic             SCmdAccept  = 1'b0;
    logic             SDataAccept = 1'b0;
    logic [1:0]       SResp = 2'b00;
    logic [31:0]      SData = '0;

    int num_checks = 0;
    int num_errors = 0;

    ocp_req_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_id      (req_id),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id),
        .rsp_err     (rsp_err),
        .MCmd        (MCmd),
        .MAddr       (MAddr),
        .MTagID      (MTagID),
        .MData       (MData),
        .MDataValid  (MDataValid),
        .MRespAccept (MRespAccept),
        .SCmdAccept  (SCmdAccept),
        .SDataAccept (SDataAccept),
        .SResp       (SResp),
        .SData       (SData)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_mcmd"}, 64'(MCmd), 64'h0);
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'h0);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
        checkOutput({tag, "_rsp_data"}, 64'(rsp_data), 64'h0);
        checkOutput({tag, "_mrespaccept"}, 64'(MRespAccept), 64'h0);
        checkOutput({tag, "_mdatavalid"}, 64'(MDataValid), 64'h0);
    endtask

    // Full transaction from IDLE; ddly = edges from command accept to data accept (0 = same edge).
    task automatic applyStimulus(input string tag, input logic [1:0] valid, input int g,
                                 input logic wr, input logic [31:0] addr, input logic [3:0] id,
                                 input logic [31:0] wdata, input int ddly, input logic [1:0] resp,
                                 input logic [31:0] sdata, input logic [31:0] exp_data,
                                 input logic exp_err);
        logic [1:0] onehot;
        onehot = 2'(1 << g);
        req_valid   = valid;
        SCmdAccept  = 1'b1;
        SDataAccept = wr && (ddly == 0);
        SResp       = 2'b00;
        tick();
        checkOutput({tag, "_mcmd"}, 64'(MCmd), wr ? 64'h1 : 64'h2);
        checkOutput({tag, "_mtagid"}, 64'(MTagID), 64'(g));
        checkOutput({tag, "_maddr"}, 64'(MAddr), 64'(addr));
        checkOutput({tag, "_mdatavalid"}, 64'(MDataValid), 64'(wr));
        if (wr) checkOutput({tag, "_mdata"}, 64'(MData), 64'(wdata));
        req_valid = 2'b00;
        tick();
        checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'(onehot));
        checkOutput({tag, "_mcmd_idle"}, 64'(MCmd), 64'h0);
        SCmdAccept  = 1'b0;
        SDataAccept = 1'b0;
        if (wr && ddly > 0) begin
            for (int i = 0; i < ddly; i++) begin
                checkOutput({tag, "_data_hold"}, 64'({MDataValid, MData}), 64'({1'b1, wdata}));
                if (i == ddly - 1) SDataAccept = 1'b1;
                tick();
            end
            SDataAccept = 1'b0;
        end
        checkOutput({tag, "_mrespaccept"}, 64'(MRespAccept), 64'h1);
        checkOutput({tag, "_mdatavalid_clr"}, 64'(MDataValid), 64'h0);
        checkOutput({tag, "_no_early_rsp"}, 64'(rsp_valid), 64'h0);
        SResp = resp;
        SData = sdata;
        tick();
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(onehot));
        checkOutput({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_data));
        checkOutput({tag, "_rsp_id"}, 64'(rsp_id), 64'(id));
        checkOutput({tag, "_rsp_err"}, 64'(rsp_err), 64'(exp_err));
        checkOutput({tag, "_mrespaccept_clr"}, 64'(MRespAccept), 64'h0);
        SResp = 2'b00;
        SData = '0;
        tick();
        checkOutput({tag, "_rsp_gone"}, 64'({rsp_valid, rsp_data, rsp_id, rsp_err}), 64'h0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        req_addr[0]  = 32'h100;
        req_addr[1]  = 32'h200;
        req_id[0]    = 4'd5;
        req_id[1]    = 4'd6;
        req_wdata[0] = 32'hAAAA5555;
        req_wdata[1] = 32'h1234;

        doReset();
        checkIdleOutputs("reset");

        // S1 read, immediate accept, DVA
        req_addr[0] = 32'h40;
        req_id[0]   = 4'd3;
        req_write   = 2'b00;
        applyStimulus("s1_read", 2'b01, 0, 1'b0, 32'h40, 4'd3, 32'h0, 0,
                      2'b01, 32'hCAFE0001, 32'hCAFE0001, 1'b0);

        // Pointer now favours S2, but a lone S1 still wins; ERR response flags an error
        applyStimulus("s1_err", 2'b01, 0, 1'b0, 32'h40, 4'd3, 32'h0, 0,
                      2'b11, 32'h0BAD0BAD, 32'h0BAD0BAD, 1'b1);

        // S2 write with data accepted three edges after command accept
        req_addr[1] = 32'h80;
        req_write   = 2'b10;
        applyStimulus("s2_write", 2'b10, 1, 1'b1, 32'h80, 4'd6, 32'h1234, 3,
                      2'b01, 32'hFFFFFFFF, 32'h0, 1'b0);

        // Round-robin from reset with both requesting
        doReset();
        req_addr[0] = 32'h100;
        req_addr[1] = 32'h200;
        req_id[0]   = 4'd5;
        req_write   = 2'b00;
        applyStimulus("rr_first", 2'b11, 0, 1'b0, 32'h100, 4'd5, 32'h0, 0,
                      2'b01, 32'h11111111, 32'h11111111, 1'b0);
        applyStimulus("rr_second", 2'b11, 1, 1'b0, 32'h200, 4'd6, 32'h0, 0,
                      2'b10, 32'h22222222, 32'h22222222, 1'b1);
        req_write = 2'b01;
        applyStimulus("rr_third", 2'b11, 0, 1'b1, 32'h100, 4'd5, 32'hAAAA5555, 0,
                      2'b01, 32'h33333333, 32'h0, 1'b0);

        // Reset while in RESP with a live response on the bus
        req_write   = 2'b00;
        req_valid   = 2'b10;
        SCmdAccept  = 1'b1;
        tick();
        req_valid   = 2'b00;
        tick();
        checkOutput("rst_resp_entry", 64'(MRespAccept), 64'h1);
        SCmdAccept = 1'b0;
        rst        = 1'b1;
        SResp      = 2'b01;
        SData      = 32'h77777777;
        tick();
        checkIdleOutputs("rst_in_resp");
        rst   = 1'b0;
        SResp = 2'b00;
        SData = '0;
        tick();
        checkOutput("rst_no_late_rsp", 64'(rsp_valid), 64'h0);
        applyStimulus("after_rst", 2'b11, 0, 1'b0, 32'h100, 4'd5, 32'h0, 0,
                      2'b01, 32'h44444444, 32'h44444444, 1'b0);

`ifdef OCP_ARB_TIMEOUT_EN
        // Watchdog: SResp held NULL, error response 8 cycles after RESP entry
        req_valid  = 2'b01;
        SCmdAccept = 1'b1;
        tick();
        req_valid  = 2'b00;
        tick();
        SCmdAccept = 1'b0;
        checkOutput("tmo_resp_entry", 64'(MRespAccept), 64'h1);
        for (int i = 0; i < 7; i++) begin
            tick();
            checkOutput("tmo_wait", 64'(rsp_valid), 64'h0);
        end
        tick();
        checkOutput("tmo_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("tmo_rsp_err", 64'(rsp_err), 64'h1);
        checkOutput("tmo_rsp_data", 64'(rsp_data), 64'h0);
        tick();
        checkOutput("tmo_idle", 64'({rsp_valid, MRespAccept}), 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
